// File: rtl/fir_pkg.sv
// Shared widths, derivations and signed types for the serial FIR MAC datapath.
package fir_pkg;

    localparam int FIR_TAPS_DEFAULT        = 64;
    localparam int FIR_DATA_WIDTH_DEFAULT  = 16;
    localparam int FIR_COEFF_WIDTH_DEFAULT = 16;

    // Tap index width; taps must be a power of two so the index wraps naturally.
    function automatic int fir_counter_bits(input int taps);
        return $clog2(taps);
    endfunction

    // Accumulator width: full product plus one growth bit per doubling of taps.
    function automatic int fir_acc_width(input int data_w, input int coeff_w, input int taps);
        return data_w + coeff_w + $clog2(taps);
    endfunction

    localparam int FIR_COUNTER_BITS_DEFAULT = fir_counter_bits(FIR_TAPS_DEFAULT);
    localparam int FIR_ACC_WIDTH_DEFAULT    =
        fir_acc_width(FIR_DATA_WIDTH_DEFAULT, FIR_COEFF_WIDTH_DEFAULT, FIR_TAPS_DEFAULT);

    typedef logic signed [FIR_DATA_WIDTH_DEFAULT-1:0]                         sample_t;
    typedef logic signed [FIR_COEFF_WIDTH_DEFAULT-1:0]                        coeff_t;
    typedef logic signed [FIR_DATA_WIDTH_DEFAULT+FIR_COEFF_WIDTH_DEFAULT-1:0] product_t;
    typedef logic signed [FIR_ACC_WIDTH_DEFAULT-1:0]                          acc_t;

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample history: one write per frame, combinational read at a tap offset
// behind the newest sample, which always sits at the write pointer.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int NUMBER_OF_TAPS = FIR_TAPS_DEFAULT,
    parameter int DATA_WIDTH     = FIR_DATA_WIDTH_DEFAULT,
    localparam int COUNTER_BITS  = fir_counter_bits(NUMBER_OF_TAPS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_wr_en,
    input  logic signed [DATA_WIDTH-1:0]  i_sample,
    input  logic [COUNTER_BITS-1:0]       i_offset,
    output logic signed [DATA_WIDTH-1:0]  o_rd_data
);

    logic signed [DATA_WIDTH-1:0] r_mem [NUMBER_OF_TAPS];
    logic [COUNTER_BITS-1:0]      r_wr_ptr;
    logic [COUNTER_BITS-1:0]      w_wr_next;
    logic [COUNTER_BITS-1:0]      w_rd_addr;

    assign w_wr_next = r_wr_ptr + {{(COUNTER_BITS-1){1'b0}}, 1'b1};
    assign w_rd_addr = r_wr_ptr - i_offset;
    assign o_rd_data = r_mem[w_rd_addr];

    // History storage and write pointer; cleared so unwritten taps read as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            for (int i = 0; i < NUMBER_OF_TAPS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[w_wr_next] <= i_sample;
            r_wr_ptr         <= w_wr_next;
        end
    end

endmodule

// File: rtl/fir_mac_datapath.sv
// Time-multiplexed FIR multiply-accumulate: one tap per enabled clock, one
// full-precision output pulse per frame once a complete frame has been seen.
module fir_mac_datapath
    import fir_pkg::*;
#(
    parameter int NUMBER_OF_TAPS = FIR_TAPS_DEFAULT,
    parameter int DATA_WIDTH     = FIR_DATA_WIDTH_DEFAULT,
    parameter int COEFF_WIDTH    = FIR_COEFF_WIDTH_DEFAULT,
    localparam int COUNTER_BITS  = fir_counter_bits(NUMBER_OF_TAPS),
    localparam int ACC_WIDTH     = fir_acc_width(DATA_WIDTH, COEFF_WIDTH, NUMBER_OF_TAPS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_enable,
    input  logic [COUNTER_BITS-1:0]       current_count,
    input  logic                          phase_min,
    input  logic signed [DATA_WIDTH-1:0]  sample_in,
    output logic [COUNTER_BITS-1:0]       coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0] coeff_in,
    output logic signed [ACC_WIDTH-1:0]   data_out,
    output logic                          data_out_valid
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
    localparam logic [COUNTER_BITS-1:0] LAST_K = COUNTER_BITS'(NUMBER_OF_TAPS - 1);

    logic signed [DATA_WIDTH-1:0] w_rd_data;
    logic signed [DATA_WIDTH-1:0] w_operand;
    logic signed [PROD_WIDTH-1:0] w_mult;
    logic signed [PROD_WIDTH-1:0] r_prod;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_acc_sum;
    logic signed [ACC_WIDTH-1:0]  w_acc_next;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [ACC_WIDTH-1:0]  r_data_out;
    logic                         w_first_k;
    logic                         w_last_k;
    logic                         r_first;
    logic                         r_last;
    logic                         r_s1_valid;
    logic                         r_armed;
    logic                         r_data_out_valid;

    fir_delay_line #(
        .NUMBER_OF_TAPS (NUMBER_OF_TAPS),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_delay_line (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (clk_enable & phase_min),
        .i_sample  (sample_in),
        .i_offset  (current_count),
        .o_rd_data (w_rd_data)
    );

    assign coeff_addr = current_count;
    // Tap 0 bypasses the memory: the new sample is written on this same edge.
    assign w_operand  = phase_min ? sample_in : w_rd_data;
    assign w_mult     = w_operand * coeff_in;
    assign w_first_k  = (current_count == '0);
    assign w_last_k   = (current_count == LAST_K);
    assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){r_prod[PROD_WIDTH-1]}}, r_prod};
    assign w_acc_sum  = r_acc + w_prod_ext;

    assign data_out       = r_data_out;
    assign data_out_valid = r_data_out_valid;

    // Accumulator restarts on the first tap of a frame.
    always_comb begin
        w_acc_next = w_acc_sum;
        if (r_first) begin
            w_acc_next = w_prod_ext;
        end else begin
            w_acc_next = w_acc_sum;
        end
    end

    // Stage 1: product register and frame-position flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prod     <= '0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
            r_s1_valid <= 1'b0;
        end else if (clk_enable) begin
            r_prod     <= w_mult;
            r_first    <= w_first_k;
            r_last     <= w_last_k;
            r_s1_valid <= 1'b1;
        end
    end

    // Stage 2: accumulate, arm on a frame start, publish on the last tap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc            <= '0;
            r_armed          <= 1'b0;
            r_data_out       <= '0;
            r_data_out_valid <= 1'b0;
        end else if (clk_enable && r_s1_valid) begin
            r_acc <= w_acc_next;
            if (r_first) begin
                r_armed <= 1'b1;
            end
            if (r_last && (r_armed || r_first)) begin
                r_data_out       <= w_acc_next;
                r_data_out_valid <= 1'b1;
            end else begin
                r_data_out_valid <= 1'b0;
            end
        end else begin
            r_data_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_mac_datapath.sv
// Scoreboard bench: a 4-tap and a 64-tap instance driven by a modelled tap counter;
// expected outputs are queued with the enabled-edge count at which they must appear.
module tb_fir_mac_datapath;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic               en4, pm4, v4;
    logic [1:0]         cnt4, addr4;
    logic signed [15:0] smp4, coeff4;
    logic signed [33:0] out4;
    logic signed [15:0] h4 [4];

    logic               en64, pm64, v64;
    logic [5:0]         cnt64, addr64;
    logic signed [15:0] smp64, coeff64;
    logic signed [37:0] out64;
    logic signed [15:0] h64 [64];

    assign coeff4  = h4[addr4];
    assign coeff64 = h64[addr64];

    fir_mac_datapath #(.NUMBER_OF_TAPS(4), .DATA_WIDTH(16), .COEFF_WIDTH(16)) dut4 (
        .clk(clk), .rst(rst), .clk_enable(en4), .current_count(cnt4), .phase_min(pm4),
        .sample_in(smp4), .coeff_addr(addr4), .coeff_in(coeff4),
        .data_out(out4), .data_out_valid(v4)
    );

    fir_mac_datapath #(.NUMBER_OF_TAPS(64), .DATA_WIDTH(16), .COEFF_WIDTH(16)) dut64 (
        .clk(clk), .rst(rst), .clk_enable(en64), .current_count(cnt64), .phase_min(pm64),
        .sample_in(smp64), .coeff_addr(addr64), .coeff_in(coeff64),
        .data_out(out64), .data_out_valid(v64)
    );

    typedef struct { longint val; int edge_no; } exp_t;
    exp_t q4[$];
    exp_t q64[$];

    int  e4 = 0, e64 = 0;
    int  c4 = 0, c64 = 0;
    int  total = 0, bad = 0;
    logic pv4 = 1'b0, pv64 = 1'b0;

    // Enabled-edge counters used as the latency reference.
    always @(posedge clk) begin
        if (en4)  e4  <= e4 + 1;
        if (en64) e64 <= e64 + 1;
    end

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever an instance pulses data_out_valid.
    initial begin
        forever begin
            exp_t x;
            @(negedge clk);
            if (v4) begin
                if (q4.size() == 0) begin
                    total++; bad++;
                    $display("FAIL stray_pulse_n4: actual=%0d required=no pulse", out4);
                end else begin
                    x = q4.pop_front();
                    chk("data_n4", longint'(out4), x.val);
                    chk("latency_n4", longint'(e4), longint'(x.edge_no));
                end
                chk("pulse_width_n4", longint'(pv4), 0);
            end
            pv4 = v4;
            if (v64) begin
                if (q64.size() == 0) begin
                    total++; bad++;
                    $display("FAIL stray_pulse_n64: actual=%0d required=no pulse", out64);
                end else begin
                    x = q64.pop_front();
                    chk("data_n64", longint'(out64), x.val);
                    chk("latency_n64", longint'(e64), longint'(x.edge_no));
                end
                chk("pulse_width_n64", longint'(pv64), 0);
            end
            pv64 = v64;
        end
    end

    task automatic tick4(input logic en, input logic signed [15:0] s);
        en4 = en; cnt4 = 2'(c4); pm4 = (c4 == 0); smp4 = s;
        @(posedge clk); #1;
        if (en) c4 = (c4 + 1) % 4;
    endtask

    task automatic tick64(input logic en, input logic signed [15:0] s);
        en64 = en; cnt64 = 6'(c64); pm64 = (c64 == 0); smp64 = s;
        @(posedge clk); #1;
        if (en) c64 = (c64 + 1) % 64;
    endtask

    // One 4-tap frame from k=0, optionally stalling stall_n cycles before tap stall_k.
    task automatic frame4(input logic signed [15:0] s, input bit push, input longint y,
                          input int stall_k, input int stall_n);
        for (int k = 0; k < 4; k++) begin
            if (k == stall_k) repeat (stall_n) tick4(1'b0, s);
            if (k == 0 && push) q4.push_back('{y, e4 + 1 + 4});
            tick4(1'b1, s);
        end
    endtask

    task automatic frame64(input logic signed [15:0] s, input longint y);
        for (int k = 0; k < 64; k++) begin
            if (k == 0) q64.push_back('{y, e64 + 1 + 64});
            tick64(1'b1, s);
        end
    endtask

    task automatic do_reset();
        en4 = 1'b0; en64 = 1'b0; pm4 = 1'b0; pm64 = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        c4 = 0; c64 = 0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) h4[i] = 16'(i + 1);
        for (int i = 0; i < 64; i++) h64[i] = -16'sd32768;
        en4 = 1'b0; cnt4 = 2'd0; pm4 = 1'b0; smp4 = 16'sd0;
        en64 = 1'b0; cnt64 = 6'd0; pm64 = 1'b0; smp64 = 16'sd0;
        rst = 1'b0;
        #2;
        chk("reset_out_n4", longint'(out4), 0);
        chk("reset_valid_n4", longint'(v4), 0);
        chk("reset_out_n64", longint'(out64), 0);
        chk("reset_valid_n64", longint'(v64), 0);
        do_reset();

        // Impulse response
        frame4(16'sd1, 1'b1, 1, -1, 0);
        frame4(16'sd0, 1'b1, 2, -1, 0);
        frame4(16'sd0, 1'b1, 3, -1, 0);
        frame4(16'sd0, 1'b1, 4, -1, 0);
        frame4(16'sd0, 1'b1, 0, -1, 0);
        tick4(1'b1, 16'sd0);
        repeat (3) tick4(1'b0, 16'sd0);
        do_reset();

        // Step response with a 7-cycle stall mid-frame
        frame4(16'sd1, 1'b1, 1, -1, 0);
        frame4(16'sd1, 1'b1, 3, -1, 0);
        frame4(16'sd1, 1'b1, 6, 2, 7);
        frame4(16'sd1, 1'b1, 10, -1, 0);
        frame4(16'sd1, 1'b1, 10, -1, 0);
        frame4(16'sd1, 1'b1, 10, -1, 0);
        tick4(1'b1, 16'sd1);
        repeat (3) tick4(1'b0, 16'sd0);
        do_reset();

        // Reset at k=2 discards the frame and the history
        frame4(16'sd1, 1'b1, 1, -1, 0);
        frame4(16'sd1, 1'b1, 3, -1, 0);
        tick4(1'b1, 16'sd1);
        tick4(1'b1, 16'sd1);
        en4 = 1'b1; cnt4 = 2'd2; pm4 = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("midreset_out_n4", longint'(out4), 0);
        chk("midreset_valid_n4", longint'(v4), 0);
        en4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; c4 = 0;
        frame4(16'sd1, 1'b1, 1, -1, 0);
        frame4(16'sd0, 1'b1, 2, -1, 0);
        frame4(16'sd0, 1'b1, 3, -1, 0);
        tick4(1'b1, 16'sd0);
        repeat (3) tick4(1'b0, 16'sd0);
        do_reset();

        // Late enable at k=3: the partial frame must not publish
        c4 = 3;
        tick4(1'b1, 16'sd5);
        frame4(16'sd1, 1'b1, 1, -1, 0);
        frame4(16'sd0, 1'b1, 2, -1, 0);
        tick4(1'b1, 16'sd0);
        repeat (3) tick4(1'b0, 16'sd0);
        do_reset();

        // Extremes on 64 taps: output grows by 2^30 per frame up to 2^36
        for (int j = 0; j < 66; j++) begin
            frame64(-16'sd32768, longint'((j < 64) ? (j + 1) : 64) <<< 30);
        end
        tick64(1'b1, 16'sd0);
        repeat (3) tick64(1'b0, 16'sd0);

        repeat (4) @(posedge clk);
        #1;
        chk("pending_n4", longint'(q4.size()), 0);
        chk("pending_n64", longint'(q64.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
